// File: rtl/pixel_frame_writer_if.sv
// rtl/pixel_frame_writer_if.sv - pixel stream input and BRAM write port bundle
interface pixel_frame_writer_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int PIXEL_WIDTH = 24
);
  logic                   s_valid;
  logic                   s_ready;
  logic [PIXEL_WIDTH-1:0] s_data;
  logic                   s_last;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [ADDR_WIDTH-1:0]  din;
  logic                   en;
  logic [3:0]             web;

  // Pixel source side: drives the stream, observes ready and the BRAM port
  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, addr, din, en, web
  );

  // Frame writer side: consumes the stream, drives the BRAM port
  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, addr, din, en, web
  );
endinterface

// File: rtl/pixel_frame_writer.sv
// rtl/pixel_frame_writer.sv - brightness-scaled RGB to GRB frame writer into shared BRAM
module pixel_frame_writer #(
  parameter int ADDR_WIDTH   = 32,
  parameter int PIXEL_WIDTH  = 24,
  parameter int PIXEL_OFFSET = 4,
  parameter int MAX_PIXELS   = 256
) (
  input  logic                 clk,
  input  logic                 aresetn,
  pixel_frame_writer_if.slave  bus,
  input  logic [7:0]           brightness,
  output logic                 frame_done,
  output logic                 overflow
);

  localparam int IDX_W = $clog2(MAX_PIXELS + 1);

  typedef enum logic [2:0] {IDLE, SCALE, WRITE_PIX, WRITE_CNT, DONE, DROP} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             bri_q, bri_d;
  logic [PIXEL_WIDTH-1:0] pix_q, pix_d;
  logic                   last_q, last_d;
  logic                   drop_q, drop_d;
  logic                   ready_q, ready_d;
  logic                   en_q, en_d;
  logic [3:0]             web_q, web_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  din_q, din_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;

  logic                   accept;
  logic [ADDR_WIDTH-1:0]  idx_inc;

  // (c * (bri + 1)) >> 8 so that bri=255 is exact unity and bri=0 is black
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    return 8'(({8'h00, c} * ({8'h00, b} + 16'd1)) >> 8);
  endfunction

  assign accept  = bus.s_valid & ready_q;
  assign idx_inc = {{(ADDR_WIDTH-IDX_W){1'b0}}, idx_q} + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  assign bus.s_ready = ready_q;
  assign bus.en      = en_q;
  assign bus.web     = web_q;
  assign bus.addr    = addr_q;
  assign bus.din     = din_q;
  assign frame_done  = done_q;
  assign overflow    = ovf_q;

  // State and registered outputs; reset abandons any partial frame
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bri_q   <= '0;
      pix_q   <= '0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      web_q   <= 4'h0;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bri_q   <= bri_d;
      pix_q   <= pix_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      web_q   <= web_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state; outputs are derived from the next state so they are registered
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bri_d   = bri_q;
    pix_d   = pix_q;
    last_d  = last_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          pix_d  = bus.s_data;
          last_d = bus.s_last;
          if (idx_q == '0) bri_d = brightness;
          state_d = SCALE;
        end
      end
      SCALE: begin
        addr_d  = idx_inc * ADDR_WIDTH'(PIXEL_OFFSET);
        din_d   = {{(ADDR_WIDTH-PIXEL_WIDTH){1'b0}},
                   scale(pix_q[15:8], bri_q), scale(pix_q[23:16], bri_q), scale(pix_q[7:0], bri_q)};
        state_d = WRITE_PIX;
      end
      WRITE_PIX: begin
        if (last_q) begin
          state_d = WRITE_CNT;
        end else if (idx_inc == ADDR_WIDTH'(MAX_PIXELS)) begin
          ovf_d   = 1'b1;
          drop_d  = 1'b1;
          state_d = WRITE_CNT;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = IDLE;
        end
        if (state_d == WRITE_CNT) begin
          addr_d = '0;
          din_d  = idx_inc;
        end
      end
      WRITE_CNT: state_d = DONE;
      DONE: begin
        idx_d = '0;
        if (drop_q) begin
          drop_d  = 1'b0;
          state_d = DROP;
        end else begin
          state_d = IDLE;
        end
      end
      DROP: begin
        if (accept && bus.s_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    en_d    = (state_d == WRITE_PIX) || (state_d == WRITE_CNT);
    web_d   = en_d ? 4'hF : 4'h0;
    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE) || (state_d == DROP);
  end

endmodule

// File: tb/tb_pixel_frame_writer.sv
// tb/tb_pixel_frame_writer.sv - self-checking bench for pixel_frame_writer
module tb_pixel_frame_writer;
  localparam int MAXP = 4;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] brightness;
  logic       frame_done;
  logic       overflow;

  pixel_frame_writer_if #(.ADDR_WIDTH(32), .PIXEL_WIDTH(24)) bus ();

  pixel_frame_writer #(
    .ADDR_WIDTH(32), .PIXEL_WIDTH(24), .PIXEL_OFFSET(4), .MAX_PIXELS(MAXP)
  ) dut (
    .clk(clk), .aresetn(aresetn), .bus(bus),
    .brightness(brightness), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  logic [63:0] wq[$];
  logic [23:0] pq[$];
  bit          ovf_model = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference scaling from plain integer arithmetic
  function automatic logic [7:0] sc(input int c, input int b);
    return 8'((c * (b + 1)) / 256);
  endfunction

  function automatic logic [31:0] grb(input logic [23:0] p, input int b);
    return {8'h00, sc(int'(p[15:8]), b), sc(int'(p[23:16]), b), sc(int'(p[7:0]), b)};
  endfunction

  // Record every BRAM write and frame_done pulse, away from the active edge
  always @(negedge clk) begin
    if (bus.en === 1'b1) begin
      wq.push_back({bus.addr, bus.din});
      chk("web_on_write", {60'h0, bus.web}, 64'hF);
    end else begin
      chk("web_idle", {60'h0, bus.web}, 64'h0);
    end
    if (frame_done === 1'b1) done_cnt++;
  end

  task automatic send(input logic [23:0] p, input bit last);
    int n;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = p;
    bus.s_last  = last;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("ready_timeout", {63'h0, bus.s_ready}, 64'h1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  // Sends pq as one frame and compares the writes with the model's memory image
  task automatic run_frame(input int bri, input bit wiggle, input string tag);
    logic [63:0] eq[$];
    int          kept, d0, n;
    wq.delete();
    d0 = done_cnt;
    brightness = 8'(bri);
    kept = (pq.size() > MAXP) ? MAXP : pq.size();
    for (int i = 0; i < kept; i++) eq.push_back({32'(4 * (i + 1)), grb(pq[i], bri)});
    eq.push_back({32'h0, 32'(kept)});
    if (pq.size() > MAXP) ovf_model = 1'b1;
    for (int i = 0; i < pq.size(); i++) begin
      send(pq[i], i == pq.size() - 1);
      if (wiggle) brightness = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    n = 0;
    while (done_cnt == d0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_write_count"}, 64'(wq.size()), 64'(eq.size()));
    for (int i = 0; i < eq.size() && i < wq.size(); i++)
      chk($sformatf("%s_write%0d", tag, i), wq[i], eq[i]);
    chk({tag, "_overflow"}, {63'h0, overflow}, {63'h0, ovf_model});
  endtask

  initial begin
    int d0, n;
    bus.s_valid = 1'b0;
    bus.s_data  = 24'h0;
    bus.s_last  = 1'b0;
    brightness  = 8'd255;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'h0, bus.s_ready}, 64'h0);
    chk("rst_en", {63'h0, bus.en}, 64'h0);
    chk("rst_addr_din", {bus.addr, bus.din}, 64'h0);
    chk("rst_done_ovf", {62'h0, frame_done, overflow}, 64'h0);
    aresetn = 1'b1;
    #1 chk("ready_low_before_edge", {63'h0, bus.s_ready}, 64'h0);
    @(negedge clk);
    chk("ready_after_release", {63'h0, bus.s_ready}, 64'h1);

    // Three primaries at unity brightness
    pq = {24'hFF0000, 24'h00FF00, 24'h0000FF};
    run_frame(255, 1'b0, "rgb");
    if (wq.size() == 4) begin
      chk("rgb_lit0", wq[0], {32'd4, 32'h0000FF00});
      chk("rgb_lit1", wq[1], {32'd8, 32'h00FF0000});
      chk("rgb_lit2", wq[2], {32'd12, 32'h000000FF});
      chk("rgb_lit3", wq[3], {32'd0, 32'd3});
    end else chk("rgb_lit_size", 64'(wq.size()), 64'd4);

    // Half brightness single pixel
    pq = {24'hC86432};
    run_frame(127, 1'b0, "half");
    if (wq.size() == 2) begin
      chk("half_lit0", wq[0], {32'd4, 32'h00326419});
      chk("half_lit1", wq[1], {32'd0, 32'd1});
    end else chk("half_lit_size", 64'(wq.size()), 64'd2);

    // Zero brightness blacks out the pixel
    pq = {24'hFFFFFF};
    run_frame(0, 1'b0, "zero");
    if (wq.size() > 0) chk("zero_lit0", wq[0], {32'd4, 32'h0});

    // Exactly full frame: no overflow
    pq.delete();
    for (int i = 0; i < MAXP; i++) pq.push_back(24'($urandom));
    run_frame(int'($urandom_range(0, 255)), 1'b0, "full");

    // Brightness change after first pixel is ignored for this frame
    pq = {24'h123456, 24'hABCDEF};
    run_frame(255, 1'b1, "bri_hold");
    if (wq.size() > 1) chk("bri_hold_unity", wq[1], {32'd8, 32'h00CDABEF});

    // Overflow frame of 6 pixels, then a normal frame restarting at addr 4
    pq.delete();
    for (int i = 0; i < 6; i++) pq.push_back(24'($urandom));
    run_frame(int'($urandom_range(0, 255)), 1'b0, "ovf");
    pq = {24'($urandom), 24'($urandom)};
    run_frame(int'($urandom_range(0, 255)), 1'b0, "after_ovf");

    // Reset after the second pixel write of a five-pixel frame
    wq.delete();
    d0 = done_cnt;
    brightness = 8'd255;
    send(24'h102030, 1'b0);
    send(24'h405060, 1'b0);
    n = 0;
    while (wq.size() < 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2 aresetn = 1'b0;
    #1;
    chk("midrst_ready", {63'h0, bus.s_ready}, 64'h0);
    chk("midrst_en_web", {59'h0, bus.en, bus.web}, 64'h0);
    chk("midrst_addr_din", {bus.addr, bus.din}, 64'h0);
    chk("midrst_done_ovf", {62'h0, frame_done, overflow}, 64'h0);
    repeat (3) @(negedge clk);
    chk("midrst_writes", 64'(wq.size()), 64'd2);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    if (wq.size() == 2) chk("midrst_pix1", wq[1], {32'd8, grb(24'h405060, 255)});
    aresetn = 1'b1;
    ovf_model = 1'b0;
    pq = {24'($urandom), 24'($urandom), 24'($urandom)};
    run_frame(int'($urandom_range(0, 255)), 1'b0, "post_rst");

    // Randomized frames, some overflowing, brightness wiggled mid-frame
    for (int f = 0; f < 10; f++) begin
      pq.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) pq.push_back(24'($urandom));
      run_frame(int'($urandom_range(0, 255)), 1'b1, $sformatf("rnd%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
